scroll_banner: RTL and testbench

SCROLL_BANNER -- requirements
Module: scroll_banner

---
 rtl/scroll_banner_pkg.sv | 29 ++
 rtl/banner_glyph_ram.sv | 31 +++
 rtl/scroll_banner.sv | 111 +++++++++++
 tb/tb_scroll_banner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scroll_banner_pkg.sv
// Glyph codes and the power-on banner text for the scrolling 7-segment display.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package scroll_banner_pkg;
   localparam int GLYPH_W = 7;
   localparam int DEF_LEN = 16;

   typedef logic [GLYPH_W-1:0] glyph_t;

   localparam glyph_t GLYPH_M     = 7'b0001001;
   localparam glyph_t GLYPH_E     = 7'b0110000;
   localparam glyph_t GLYPH_R     = 7'b0111001;
   localparam glyph_t GLYPH_Y     = 7'b1000100;
   localparam glyph_t GLYPH_X     = 7'b1001000;
   localparam glyph_t GLYPH_DASH  = 7'b1111110;
   localparam glyph_t GLYPH_A     = 7'b0001000;
   localparam glyph_t GLYPH_S     = 7'b0100100;
   localparam glyph_t GLYPH_BLANK = 7'b1111111;

   localparam glyph_t DEFAULT_MSG [DEF_LEN] = '{
      GLYPH_M, GLYPH_E, GLYPH_R, GLYPH_R, GLYPH_Y, GLYPH_BLANK, GLYPH_BLANK, GLYPH_X,
      GLYPH_DASH, GLYPH_M, GLYPH_A, GLYPH_S, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK
   };

   // Entries past the built-in text are blank.
   function automatic glyph_t default_glyph(input int idx);
      if (idx < DEF_LEN) return DEFAULT_MSG[idx[3:0]];
      return GLYPH_BLANK;
   endfunction
endpackage

// File: rtl/banner_glyph_ram.sv
// MSG_LEN x 7 glyph store: resets to the default banner, one write port,
// one combinational read port. Out-of-range writes are dropped.
module banner_glyph_ram
   import scroll_banner_pkg::*;
#(
   parameter int MSG_LEN = 16,
   parameter int AW      = $clog2(MSG_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  glyph_t        wr_data,
   input  logic [AW-1:0] rd_addr,
   output glyph_t        rd_data
);
   glyph_t r_mem [MSG_LEN];
   logic   w_wr_ok;

   assign w_wr_ok = wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_LEN));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MSG_LEN; i++) r_mem[i] <= default_glyph(i);
      end else if (w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];
endmodule

// File: rtl/scroll_banner.sv
// Multiplexed 7-segment scrolling banner: digit scan, frame-based scroll
// stepping, and registered segment/anode drive.
module scroll_banner
   import scroll_banner_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int MSG_LEN    = 16,
   parameter int SCAN_DIV   = 50000,
   parameter int STEP_DIV   = 100,
   localparam int AW        = $clog2(MSG_LEN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  dir,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [6:0]            wr_data,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic [AW-1:0]         pos,
   output logic                  wrap
);
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int SW = AW + 4;

   logic [CW-1:0]         r_scan;
   logic [DW-1:0]         r_digit;
   logic [FW-1:0]         r_frame;
   logic [AW-1:0]         r_pos;
   logic                  r_wrap;
   logic [6:0]            r_seg;
   logic [NUM_DIGITS-1:0] r_an;

   logic          w_scan_tc, w_frame_tick, w_step, w_wrap_next;
   logic [AW-1:0] w_pos_next, w_rd_addr;
   logic [SW-1:0] w_sum;
   glyph_t        w_glyph;

   assign w_scan_tc    = (r_scan == CW'(SCAN_DIV-1));
   assign w_frame_tick = w_scan_tc && (r_digit == DW'(NUM_DIGITS-1));
   assign w_step       = w_frame_tick && en && (r_frame == FW'(STEP_DIV-1));

   // True modulo so short messages and NUM_DIGITS > MSG_LEN both wrap correctly.
   assign w_sum     = SW'(r_pos) + SW'(r_digit);
   assign w_rd_addr = AW'(w_sum % SW'(MSG_LEN));

   always_comb begin
      w_pos_next  = r_pos;
      w_wrap_next = 1'b0;
      if (w_step) begin
         if (!dir) begin
            if (r_pos == AW'(MSG_LEN-1)) begin
               w_pos_next  = '0;
               w_wrap_next = 1'b1;
            end else begin
               w_pos_next = r_pos + 1'b1;
            end
         end else begin
            if (r_pos == '0) begin
               w_pos_next  = AW'(MSG_LEN-1);
               w_wrap_next = 1'b1;
            end else begin
               w_pos_next = r_pos - 1'b1;
            end
         end
      end
   end

   banner_glyph_ram #(.MSG_LEN(MSG_LEN), .AW(AW)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (w_rd_addr),
      .rd_data (w_glyph)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scan  <= '0;
         r_digit <= '0;
         r_frame <= '0;
         r_pos   <= '0;
         r_wrap  <= 1'b0;
         r_seg   <= GLYPH_BLANK;
         r_an    <= '1;
      end else begin
         r_scan <= w_scan_tc ? '0 : r_scan + 1'b1;
         if (w_scan_tc)
            r_digit <= (r_digit == DW'(NUM_DIGITS-1)) ? '0 : r_digit + 1'b1;
         // Holding the frame count at 0 while disabled makes a re-enable wait a full step.
         if (!en)
            r_frame <= '0;
         else if (w_frame_tick)
            r_frame <= (r_frame == FW'(STEP_DIV-1)) ? '0 : r_frame + 1'b1;
         r_pos  <= w_pos_next;
         r_wrap <= w_wrap_next;
         r_seg  <= w_glyph;
         r_an   <= ~(NUM_DIGITS'(1) << r_digit);
      end
   end

   assign seg  = r_seg;
   assign an   = r_an;
   assign pos  = r_pos;
   assign wrap = r_wrap;
endmodule

// File: tb/tb_scroll_banner.sv
// Directed bench for scroll_banner: a 16-glyph and a 10-glyph instance share
// clock and controls; expected display slots and positions flow through queues.
module tb_scroll_banner;
   localparam logic [6:0] G_M = 7'b0001001, G_E = 7'b0110000, G_R = 7'b0111001;
   localparam logic [6:0] G_D = 7'b1111110, G_B = 7'b1111111, G_W = 7'b1000000;
   localparam logic [3:0] AN_EXP [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
   } slot_t;

   logic       clk, rst, en, dir;
   logic       wr_en, wr_en10;
   logic [3:0] wr_addr, wr_addr10;
   logic [6:0] wr_data, wr_data10;
   logic [6:0] seg, seg10;
   logic [3:0] an, an10, pos, pos10;
   logic       wrap, wrap10;

   slot_t sb[$];
   int    pq[$];
   int    n_chk = 0, n_fail = 0, wrap_seen = 0;

   scroll_banner #(.NUM_DIGITS(4), .MSG_LEN(16), .SCAN_DIV(2), .STEP_DIV(1)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .seg(seg), .an(an), .pos(pos), .wrap(wrap));

   scroll_banner #(.NUM_DIGITS(4), .MSG_LEN(10), .SCAN_DIV(2), .STEP_DIV(1)) dut10 (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .wr_en(wr_en10), .wr_addr(wr_addr10),
      .wr_data(wr_data10), .seg(seg10), .an(an10), .pos(pos10), .wrap(wrap10));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] cur_an(input bit sel);
      return sel ? an10 : an;
   endfunction
   function automatic logic [6:0] cur_seg(input bit sel);
      return sel ? seg10 : seg;
   endfunction
   function automatic logic [3:0] cur_pos(input bit sel);
      return sel ? pos10 : pos;
   endfunction
   function automatic logic cur_wrap(input bit sel);
      return sel ? wrap10 : wrap;
   endfunction

   task automatic push_slot(input int d, input logic [6:0] g);
      slot_t s;
      s.an  = AN_EXP[d];
      s.seg = g;
      sb.push_back(s);
   endtask

   // Lands on the first cycle in which tgt is driven.
   task automatic wait_an(input bit sel, input logic [3:0] tgt);
      int n = 0;
      while (cur_an(sel) === tgt && n < 20) begin tick(); n++; end
      while (cur_an(sel) !== tgt && n < 20) begin tick(); n++; end
   endtask

   task automatic drain(input bit sel, input string tag);
      slot_t s;
      while (sb.size() > 0) begin
         s = sb.pop_front();
         wait_an(sel, s.an);
         chk({tag, "_an"}, cur_an(sel), s.an);
         chk({tag, "_seg"}, cur_seg(sel), s.seg);
      end
   endtask

   task automatic wait_pos_change(input bit sel, input string tag);
      logic [3:0] p0;
      int n = 0;
      p0 = cur_pos(sel);
      do begin
         tick();
         n++;
         if (cur_wrap(sel) === 1'b1) wrap_seen++;
      end while (cur_pos(sel) === p0 && n < 40);
      chk({tag, "_moved"}, cur_pos(sel) !== p0, 1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; dir = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      wr_en10 = 1'b0; wr_addr10 = '0; wr_data10 = '0;
      tick(); tick();
      chk("rst_seg", seg, G_B);
      chk("rst_an", an, 4'b1111);
      chk("rst_pos", pos, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_an10", an10, 4'b1111);

      // Scan with scrolling disabled
      rst = 1'b0;
      tick();
      chk("first_an", an, 4'b1110);
      chk("first_seg", seg, G_M);
      push_slot(1, G_E); push_slot(2, G_R); push_slot(3, G_R); push_slot(0, G_M);
      drain(0, "scan");
      chk("hold_pos", pos, 0);

      // Scroll left through a full lap
      en = 1'b1;
      wrap_seen = 0;
      for (int s = 1; s <= 16; s++) begin
         pq.push_back(s % 16);
         wait_pos_change(0, "left");
         chk("left_pos", pos, pq.pop_front());
         chk("left_wrap", wrap, (s == 16));
      end
      tick();
      chk("wrap_one_cycle", wrap, 0);
      chk("wrap_count", wrap_seen, 1);

      // Scroll right from 0
      dir = 1'b1;
      wait_pos_change(0, "right");
      chk("right_pos", pos, 15);
      chk("right_wrap", wrap, 1);
      en = 1'b0;
      push_slot(0, G_B); push_slot(1, G_M); push_slot(2, G_E); push_slot(3, G_R);
      drain(0, "right_disp");
      chk("right_hold", pos, 15);

      // Write a displayed glyph
      en = 1'b1; dir = 1'b0;
      wait_pos_change(0, "back");
      chk("back_pos", pos, 0);
      en = 1'b0;
      wait_an(0, 4'b0111);
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = G_W;
      tick();
      wr_en = 1'b0;
      tick();
      chk("wr_an", an, 4'b1110);
      chk("wr_seg", seg, G_W);
      push_slot(1, G_E); push_slot(2, G_R); push_slot(3, G_R); push_slot(0, G_W);
      drain(0, "wr_disp");

      // Reset in the middle of scrolling
      en = 1'b1;
      for (int n = 0; n < 100 && pos !== 4'd5; n++) tick();
      chk("mid_pos", pos, 5);
      rst = 1'b1;
      #1;
      chk("mid_rst_seg", seg, G_B);
      chk("mid_rst_an", an, 4'b1111);
      chk("mid_rst_pos", pos, 0);
      chk("mid_rst_wrap", wrap, 0);
      chk("mid_rst_pos10", pos10, 0);
      en = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("rel_an", an, 4'b1110);
      chk("rel_seg", seg, G_M);
      push_slot(1, G_E); push_slot(2, G_R); push_slot(3, G_R);
      drain(0, "restored");

      // Non-power-of-two message length
      en = 1'b1;
      for (int n = 0; n < 200 && pos10 !== 4'd8; n++) tick();
      en = 1'b0;
      chk("ten_pos8", pos10, 8);
      push_slot(0, G_D); push_slot(1, G_M); push_slot(2, G_M); push_slot(3, G_E);
      drain(1, "ten_disp");
      en = 1'b1;
      wait_pos_change(1, "ten_a");
      chk("ten_pos9", pos10, 9);
      wait_pos_change(1, "ten_b");
      chk("ten_pos0", pos10, 0);
      chk("ten_wrap", wrap10, 1);
      en = 1'b0;
      wr_en10 = 1'b1; wr_addr10 = 4'd12; wr_data10 = 7'b0000000;
      tick();
      wr_en10 = 1'b0;
      push_slot(0, G_M); push_slot(1, G_E); push_slot(2, G_R); push_slot(3, G_R);
      drain(1, "ten_oob");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
